calc_sequencer: RTL

Command sequencer sitting directly upstream of the 10×8-bit register bank, and the sole master of its port. It accepts one calculator command at a time, reads up to two operands through the bank's single shared address/rdata port, and computes an 8-bit result. It then writes the result back to a destination register and reports completion and a status flag to the keypad/display front end.

---
 rtl/calc_sequencer_if.sv | 31 +++
 rtl/calc_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/calc_sequencer_if.sv
// Command and register-bank port bundle for calc_sequencer.
// master = keypad/display front end plus bank; slave = the sequencer itself.
interface calc_sequencer_if #(
  parameter int W = 8
);
  logic         start;
  logic [2:0]   op;
  logic [3:0]   addr_a;
  logic [3:0]   addr_b;
  logic [3:0]   addr_d;
  logic [W-1:0] imm;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] result;
  logic         flag;
  logic         rb_we;
  logic [3:0]   rb_address;
  logic [W-1:0] rb_wdata;
  logic [W-1:0] rb_rdata;

  modport master (
    output start, op, addr_a, addr_b, addr_d, imm, rb_rdata,
    input  busy, done, err, result, flag, rb_we, rb_address, rb_wdata
  );

  modport slave (
    input  start, op, addr_a, addr_b, addr_d, imm, rb_rdata,
    output busy, done, err, result, flag, rb_we, rb_address, rb_wdata
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator command sequencer: reads two operands from the register bank,
// executes one ALU op, writes the result back and pulses done/err.
module calc_sequencer #(
  parameter int NREGS = 10,
  parameter int W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  calc_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  logic [2:0]   state_q, state_d;
  logic [2:0]   op_q;
  logic [3:0]   addr_a_q, addr_b_q, addr_d_q;
  logic [W-1:0] imm_q;
  logic [W-1:0] opa_q, opb_q;
  logic [W-1:0] result_q, result_d;
  logic         flag_q, flag_d;
  logic         legal;
  logic [3:0]   rb_address;

  function automatic logic addr_ok(input logic [3:0] a);
    return int'(a) < NREGS;
  endfunction

  // Returns {flag, result} for one operation.
  function automatic logic [W:0] exec_op(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] imm);
    logic [W:0]     wide;
    logic [2*W-1:0] prod;
    logic [W-1:0]   res;
    wide = '0;
    prod = '0;
    res  = '0;
    case (op)
      OP_ADD: wide = {1'b0, a} + {1'b0, b};
      OP_SUB: wide = {1'b0, a} - {1'b0, b};
      OP_AND: begin res = a & b; wide = {(res == '0), res}; end
      OP_OR:  begin res = a | b; wide = {(res == '0), res}; end
      OP_LDI: wide = {1'b0, imm};
      OP_MUL: begin
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        wide = {(prod[2*W-1:W] != '0), prod[W-1:0]};
      end
      default: wide = '0;
    endcase
    return wide;
  endfunction

  assign legal = (bus.op <= OP_MUL) && addr_ok(bus.addr_d) &&
                 ((bus.op == OP_LDI) || (addr_ok(bus.addr_a) && addr_ok(bus.addr_b)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (!legal)                 state_d = S_ERR;
          else if (bus.op == OP_LDI)  state_d = S_EXEC;
          else                        state_d = S_RD_A;
        end
      end
      S_RD_A:  state_d = S_RD_B;
      S_RD_B:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WR;
      S_WR:    state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    {flag_d, result_d} = {flag_q, result_q};
    if (state_q == S_EXEC) {flag_d, result_d} = exec_op(op_q, opa_q, opb_q, imm_q);
  end

  // Control and visible status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  // Command latch and operand capture; meaningful only once a command is in flight
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.start) begin
      op_q     <= bus.op;
      addr_a_q <= bus.addr_a;
      addr_b_q <= bus.addr_b;
      addr_d_q <= bus.addr_d;
      imm_q    <= bus.imm;
    end
    if (state_q == S_RD_A) opa_q <= bus.rb_rdata;
    if (state_q == S_RD_B) opb_q <= bus.rb_rdata;
  end

  always_comb begin
    rb_address = 4'd0;
    case (state_q)
      S_RD_A:  rb_address = addr_a_q;
      S_RD_B:  rb_address = addr_b_q;
      S_WR:    rb_address = addr_d_q;
      default: rb_address = 4'd0;
    endcase
  end

  assign bus.rb_address = rb_address;
  assign bus.rb_we      = (state_q == S_WR);
  assign bus.rb_wdata   = result_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_FIN) || (state_q == S_ERR);
  assign bus.err        = (state_q == S_ERR);
  assign bus.result     = result_q;
  assign bus.flag       = flag_q;

endmodule
